// File: rtl/path_trace_pkg.sv
// Shared definitions for the shortest-path traceback reader: direction codes written by the
// solver into P, default bus widths and the traceback FSM state encoding.
package path_trace_pkg;

  localparam int unsigned DefDWidth = 8;
  localparam int unsigned DefAWidth = 13;

  localparam logic [7:0] CodeStart = 8'h08;
  localparam logic [7:0] CodeRight = 8'h09;
  localparam logic [7:0] CodeDown  = 8'h0A;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWait,
    StDec,
    StFin
  } state_t;

endpackage

// File: rtl/path_trace_addr.sv
// Row-major cell address generator: addr = row * SIZE_ROW + col, truncated to A_WIDTH.
module path_trace_addr
  import path_trace_pkg::*;
#(
  parameter int unsigned SIZE_ROW = 4,
  parameter int unsigned A_WIDTH  = DefAWidth
) (
  input  logic [A_WIDTH-1:0] row,
  input  logic [A_WIDTH-1:0] col,
  output logic [A_WIDTH-1:0] addr
);

  assign addr = row * A_WIDTH'(SIZE_ROW) + col;

endmodule

// File: rtl/path_trace.sv
// Traceback reader: walks P from the bottom-right cell back to Start, logging addresses into T.
// Optional macro COST_SUM_EN also reads M alongside P and accumulates the path cost.
module path_trace
  import path_trace_pkg::*;
#(
  parameter int unsigned SIZE_ROW = 4,
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned D_WIDTH  = DefDWidth,
  parameter int unsigned A_WIDTH  = DefAWidth
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic [D_WIDTH-1:0] P_In,
  input  logic [D_WIDTH-1:0] M_In,
  output logic [A_WIDTH-1:0] P_Addr,
  output logic               P_En,
  output logic               P_Rw,
  output logic [A_WIDTH-1:0] M_Addr,
  output logic               M_En,
  output logic               M_Rw,
  output logic [A_WIDTH-1:0] T_Addr,
  output logic [A_WIDTH-1:0] T_Out,
  output logic               T_En,
  output logic               T_Rw,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [A_WIDTH-1:0] Len,
  output logic [15:0]        Cost
);

  localparam logic [D_WIDTH-1:0] DStart = D_WIDTH'(CodeStart);
  localparam logic [D_WIDTH-1:0] DRight = D_WIDTH'(CodeRight);
  localparam logic [D_WIDTH-1:0] DDown  = D_WIDTH'(CodeDown);

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] row_q, row_d, col_q, col_d, k_q, k_d, len_q, len_d;
  logic [A_WIDTH-1:0] p_addr_q, p_addr_d, t_addr_q, t_addr_d, t_out_q, t_out_d;
  logic [A_WIDTH-1:0] next_addr;
  logic [D_WIDTH-1:0] code_q, code_d;
  logic               p_en_q, p_en_d, t_en_q, t_en_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

  path_trace_addr #(
    .SIZE_ROW(SIZE_ROW),
    .A_WIDTH (A_WIDTH)
  ) u_addr (
    .row (row_d),
    .col (col_d),
    .addr(next_addr)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    k_d      = k_q;
    len_d    = len_q;
    code_d   = code_q;
    t_en_d   = 1'b0;
    t_addr_d = t_addr_q;
    t_out_d  = t_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (Go) begin
          row_d   = A_WIDTH'(NUM_ROWS - 1);
          col_d   = A_WIDTH'(SIZE_ROW - 1);
          k_d     = '0;
          len_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StRd;
        end
      end
      StRd:   state_d = StWait;
      StWait: begin
        code_d  = P_In;
        state_d = StDec;
      end
      StDec: begin
        // p_addr_q still holds the address of the cell whose code is being decoded.
        t_addr_d = k_q;
        t_out_d  = p_addr_q;
        if (code_q == DStart) begin
          t_en_d  = 1'b1;
          len_d   = k_q + A_WIDTH'(1);
          state_d = StFin;
        end else if (code_q == DRight && col_q != '0) begin
          t_en_d  = 1'b1;
          k_d     = k_q + A_WIDTH'(1);
          col_d   = col_q - A_WIDTH'(1);
          state_d = StRd;
        end else if (code_q == DDown && row_q != '0) begin
          t_en_d  = 1'b1;
          k_d     = k_q + A_WIDTH'(1);
          row_d   = row_q - A_WIDTH'(1);
          state_d = StRd;
        end else begin
          t_addr_d = t_addr_q;
          t_out_d  = t_out_q;
          err_d    = 1'b1;
          len_d    = k_q;
          state_d  = StFin;
        end
        if (state_d == StFin) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory reads are issued on entry to RD so the registered enable lines up with the RD cycle.
  always_comb begin
    p_en_d   = 1'b0;
    p_addr_d = p_addr_q;
    if (state_d == StRd) begin
      p_en_d   = 1'b1;
      p_addr_d = next_addr;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      len_q    <= '0;
      code_q   <= '0;
      p_addr_q <= '0;
      p_en_q   <= 1'b0;
      t_addr_q <= '0;
      t_out_q  <= '0;
      t_en_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      k_q      <= k_d;
      len_q    <= len_d;
      code_q   <= code_d;
      p_addr_q <= p_addr_d;
      p_en_q   <= p_en_d;
      t_addr_q <= t_addr_d;
      t_out_q  <= t_out_d;
      t_en_q   <= t_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef COST_SUM_EN
  logic [D_WIDTH-1:0] m_q;
  logic [A_WIDTH-1:0] m_addr_q;
  logic               m_en_q;
  logic [15:0]        cost_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      m_q      <= '0;
      m_addr_q <= '0;
      m_en_q   <= 1'b0;
      cost_q   <= '0;
    end else begin
      m_en_q   <= p_en_d;
      m_addr_q <= p_addr_d;
      if (state_q == StWait) m_q <= M_In;
      if (state_q == StIdle && Go) begin
        cost_q <= '0;
      end else if (t_en_d) begin
        cost_q <= cost_q + 16'(m_q);
      end
    end
  end

  assign M_En   = m_en_q;
  assign M_Addr = m_addr_q;
  assign Cost   = cost_q;
`else
  logic unused_m_in;
  assign unused_m_in = ^M_In;
  assign M_En        = 1'b0;
  assign M_Addr      = '0;
  assign Cost        = '0;
`endif

  assign P_Addr = p_addr_q;
  assign P_En   = p_en_q;
  assign P_Rw   = 1'b0;
  assign M_Rw   = 1'b0;
  assign T_Addr = t_addr_q;
  assign T_Out  = t_out_q;
  assign T_En   = t_en_q;
  assign T_Rw   = t_en_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Err    = err_q;
  assign Len    = len_q;

endmodule

// File: tb/tb_path_trace.sv
// Self-checking bench for path_trace: directed and random P matrices against a path-walk model.
module tb_path_trace;

  localparam int SR = 4;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go  = 1'b0;
  logic [DW-1:0] p_in, m_in;
  logic [AW-1:0] p_addr, m_addr, t_addr, t_out, len;
  logic          p_en, p_rw, m_en, m_rw, t_en, t_rw, busy, done, err;
  logic [15:0]   cost;

  always #5 clk = ~clk;

  path_trace #(
    .SIZE_ROW(SR),
    .NUM_ROWS(NR),
    .D_WIDTH (DW),
    .A_WIDTH (AW)
  ) u_dut (
    .Clk   (clk),
    .Rst   (rst),
    .Go    (go),
    .P_In  (p_in),
    .M_In  (m_in),
    .P_Addr(p_addr),
    .P_En  (p_en),
    .P_Rw  (p_rw),
    .M_Addr(m_addr),
    .M_En  (m_en),
    .M_Rw  (m_rw),
    .T_Addr(t_addr),
    .T_Out (t_out),
    .T_En  (t_en),
    .T_Rw  (t_rw),
    .Busy  (busy),
    .Done  (done),
    .Err   (err),
    .Len   (len),
    .Cost  (cost)
  );

  // Synchronous single-port SRAM models and a log of every T write.
  logic [7:0]    p_mem[16];
  logic [7:0]    m_mem[16];
  logic [DW-1:0] p_rd = '0;
  logic [DW-1:0] m_rd = '0;
  logic          m_en_seen = 1'b0;
  int unsigned   t_addr_log[$];
  int unsigned   t_data_log[$];

  assign p_in = p_rd;
  assign m_in = m_rd;

  always @(posedge clk) begin
    if (p_en && !p_rw) p_rd <= p_mem[p_addr[3:0]];
    if (m_en && !m_rw) m_rd <= m_mem[m_addr[3:0]];
    if (m_en) m_en_seen <= 1'b1;
    if (t_en && t_rw) begin
      t_addr_log.push_back(32'(t_addr));
      t_data_log.push_back(32'(t_out));
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: follow the direction codes from (NR-1, SR-1) until Start or an illegal move.
  int unsigned exp_path[$];
  int          exp_err, exp_len, exp_cost, exp_cycles;

  task automatic ref_walk();
    int r = NR - 1;
    int c = SR - 1;
    int reads = 0;
    bit stop = 0;
    exp_path.delete();
    exp_err  = 0;
    exp_cost = 0;
    for (int i = 0; i < 64 && !stop; i++) begin
      int a = r * SR + c;
      reads++;
      if (p_mem[a] == 8'h08) begin
        exp_path.push_back(a);
        exp_cost += m_mem[a];
        stop = 1;
      end else if (p_mem[a] == 8'h09 && c > 0) begin
        exp_path.push_back(a);
        exp_cost += m_mem[a];
        c--;
      end else if (p_mem[a] == 8'h0A && r > 0) begin
        exp_path.push_back(a);
        exp_cost += m_mem[a];
        r--;
      end else begin
        exp_err = 1;
        stop    = 1;
      end
    end
    exp_len    = exp_path.size();
    exp_cycles = 3 * reads + 2;
`ifndef COST_SUM_EN
    exp_cost = 0;
`endif
    exp_cost = exp_cost % 65536;
  endtask

  // One Go pulse; optionally a second Go pulse at cycle extra_go while the walk is in flight.
  task automatic run_walk(input string tag, input int extra_go);
    int base = t_addr_log.size();
    int n = 1;
    int done_n = 0;
    int dones = 0;
    logic busy_at_done = 1'b1;
    ref_walk();
    @(negedge clk);
    go = 1'b1;
    for (int c = 0; c < 300 && dones == 0; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 2) begin
        go = 1'b0;
        check_val({tag, " busy_after_go"}, 32'(busy), 32'd1);
      end
      if (extra_go > 0 && n == extra_go) go = 1'b1;
      if (extra_go > 0 && n == extra_go + 1) go = 1'b0;
      if (done) begin
        dones++;
        done_n = n;
        busy_at_done = busy;
      end
    end
    check_val({tag, " done_cycle"}, 32'(done_n), 32'(exp_cycles));
    check_val({tag, " busy_at_done"}, 32'(busy_at_done), 32'd0);
    check_val({tag, " err"}, 32'(err), 32'(exp_err));
    check_val({tag, " len"}, 32'(len), 32'(exp_len));
    check_val({tag, " cost"}, 32'(cost), 32'(exp_cost));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check_val({tag, " done_pulses"}, 32'(dones), 32'd1);
    check_val({tag, " len_held"}, 32'(len), 32'(exp_len));
    check_val({tag, " t_writes"}, 32'(t_addr_log.size() - base), 32'(exp_path.size()));
    for (int i = 0; i < exp_path.size(); i++) begin
      logic [31:0] ga = 32'hdead_beef;
      logic [31:0] gd = 32'hdead_beef;
      if (base + i < t_addr_log.size()) begin
        ga = t_addr_log[base+i];
        gd = t_data_log[base+i];
      end
      check_val($sformatf("%s t_addr[%0d]", tag, i), ga, 32'(i));
      check_val($sformatf("%s t_data[%0d]", tag, i), gd, exp_path[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      p_mem[i] = 8'h0A;
      m_mem[i] = 8'h03;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst done", 32'(done), 32'd0);
    check_val("rst err", 32'(err), 32'd0);
    check_val("rst len", 32'(len), 32'd0);
    check_val("rst cost", 32'(cost), 32'd0);
    check_val("rst enables", 32'({p_en, m_en, t_en, t_rw}), 32'd0);
    check_val("rst addrs", 32'({p_addr, t_addr, t_out}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Nominal: up column 3 to row 0, then left along row 0.
    p_mem[0] = 8'h08;
    for (int i = 1; i < 4; i++) p_mem[i] = 8'h09;
    run_walk("nominal", 0);
    check_val("nominal len7", 32'(len), 32'd7);
`ifdef COST_SUM_EN
    check_val("nominal cost21", 32'(cost), 32'd21);
`endif

    // All-right along the bottom row.
    for (int i = 0; i < 16; i++) p_mem[i] = 8'h0A;
    p_mem[12] = 8'h08;
    for (int i = 13; i < 16; i++) p_mem[i] = 8'h09;
    run_walk("row3", 0);
    check_val("row3 len4", 32'(len), 32'd4);

    // Down past row 0 is illegal.
    for (int i = 0; i < 16; i++) p_mem[i] = 8'h0A;
    run_walk("oob", 0);
    check_val("oob err", 32'(err), 32'd1);
    check_val("oob len3", 32'(len), 32'd3);

    // Unknown code at the first cell.
    p_mem[15] = 8'h00;
    run_walk("invalid", 0);
    check_val("invalid len0", 32'(len), 32'd0);

    // Second Go mid-walk must be ignored.
    p_mem[0] = 8'h08;
    for (int i = 1; i < 4; i++) p_mem[i] = 8'h09;
    for (int i = 4; i < 16; i++) p_mem[i] = 8'h0A;
    run_walk("go_busy", 6);

    // Reset mid-walk aborts to IDLE with all outputs cleared.
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst flags", 32'({busy, done, err, p_en, m_en, t_en, t_rw}), 32'd0);
    check_val("midrst len", 32'(len), 32'd0);
    check_val("midrst addrs", 32'({p_addr, t_addr}), 32'd0);
    check_val("midrst cost", 32'(cost), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_walk("post_rst", 0);

    // Random matrices, mostly legal moves with occasional Start and garbage codes.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) begin
        int unsigned r = $urandom_range(0, 99);
        if (r < 8) p_mem[i] = 8'h08;
        else if (r < 50) p_mem[i] = 8'h09;
        else if (r < 93) p_mem[i] = 8'h0A;
        else p_mem[i] = 8'($urandom);
        m_mem[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) p_mem[0] = 8'h08;
      run_walk($sformatf("rand%0d", t), 0);
    end

`ifndef COST_SUM_EN
    check_val("m_en_never", 32'(m_en_seen), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/path_trace.md
Name: path_trace

Overview:
- Traceback reader for the shortest-path direction memory P, which the shortest-path solver fills with one code per cell: Start=8'h08, Right=8'h09, Down=8'h0A.
- On Go, walks from the bottom-right cell back to the Start cell, following each direction code.
- Writes the visited cell addresses in visit order into trace memory T, then reports path length and an error flag.
- Sits beside the solver on the same single-port synchronous SRAMs and runs after the solver's Done.

Parameters:
- SIZE_ROW, 4, columns per row (row-major layout: addr = row*SIZE_ROW + col)
- NUM_ROWS, 4, rows in the matrix
- D_WIDTH, 8, P/M data width
- A_WIDTH, 13, address width for P, M and T

Ports:
- Clk  input  1  clock, rising edge
- Rst  input  1  synchronous active-low reset; 0 on a rising Clk edge resets
- Go  input  1  start request, sampled only in IDLE
- P_In  input  D_WIDTH  P read data, valid the cycle after P_En=1 with P_Rw=0
- M_In  input  D_WIDTH  M read data, same timing as P_In (used only with COST_SUM_EN)
- P_Addr  output  A_WIDTH  P address
- P_En  output  1  P enable
- P_Rw  output  1  always 0 (read only)
- M_Addr  output  A_WIDTH  M address
- M_En  output  1  M enable
- M_Rw  output  1  always 0
- T_Addr  output  A_WIDTH  trace index k
- T_Out  output  A_WIDTH  visited cell address
- T_En  output  1  T enable
- T_Rw  output  1  1 = write
- Busy  output  1  high from Go acceptance until Done
- Done  output  1  one-cycle completion pulse
- Err  output  1  held from Done until next Go acceptance
- Len  output  A_WIDTH  cells written to T, held after Done
- Cost  output  16  sum of M along the path (0 without COST_SUM_EN)

Behaviour:
- Reset value 0 for all outputs, row/col/k counters and the state register.
- Reset mid-walk aborts to IDLE and leaves T partially written.
- All outputs are registered.
- IDLE:
  - Go=1: row=NUM_ROWS-1, col=SIZE_ROW-1, k=0; clear Len/Err/Cost; Busy=1; go to RD.
  - Go=0: stay in IDLE.
- RD (1 cycle): P_En=1, P_Addr=row*SIZE_ROW+col. With the macro also M_En=1, M_Addr=same. Go to WAIT.
- WAIT (1 cycle): capture P_In (and M_In) into internal registers; all enables 0. Go to DEC.
- DEC (1 cycle): decode the captured code.
  - Start: write T[k]=addr, Len=k+1, go to FIN.
  - Right with col>0: write T[k], k++, col--, go to RD.
  - Down with row>0: write T[k], k++, row--, go to RD.
  - Right with col=0, Down with row=0, or any other code: no T write, Err=1, Len=k, go to FIN.
  - A T write drives T_En=1, T_Rw=1, T_Addr=k, T_Out=addr.
- FIN: Done=1 for one cycle, Busy=0, return to IDLE.
- Throughput: 3 cycles per cell. Total cycles from Go sample to Done = 3*cells + 2.
- Every valid move strictly decreases row+col, so the walk terminates within NUM_ROWS+SIZE_ROW-1 cells. No separate loop guard.
- Go while Busy is ignored. Go held high re-triggers on the cycle after FIN.
- A Start code at a cell other than (0,0) is accepted as the end of the path.
- Address arithmetic is done at A_WIDTH and truncated. Cost adds zero-extended M values, wrapping modulo 2^16.

Optional Feature:
- COST_SUM_EN
  - Defined: M is read in parallel with P in RD; DEC adds the captured M value into Cost for each cell written to T, including the Start cell.
  - Undefined: M_En, M_Addr and Cost are tied to 0 and the M capture register is omitted.

Decomposition:
- Shared package holds:
  - direction code constants START=8'h08, RIGHT=8'h09, DOWN=8'h0A, which the solver also uses
  - default D_WIDTH/A_WIDTH
  - state encoding IDLE/RD/WAIT/DEC/FIN
- One natural sub-module: path_trace_addr, a combinational row*SIZE_ROW+col address generator.

Test Plan:
- Nominal path, 4x4: P[0]=08, P[1..3]=09, all other P=0A; Go pulse.
  - T[0..6] = 15, 11, 7, 3, 2, 1, 0.
  - Len=7, Err=0, Done 23 cycles after Go sample.
- All-right path on row 3:
  - Setup: P[12]=08, P[13..15]=09, with P[0..11] holding 0A filler.
  - Result: T = 15, 14, 13, 12; Len=4.
- Out-of-bounds move: P[15]=0A, P[11]=0A, P[7]=0A, P[3]=0A.
  - Err=1, Len=3.
  - T[0..2] = 15, 11, 7; T[3] is not written.
- Invalid code: P[15]=8'h00 -> Err=1, Len=0, no T_En pulse, Done after 5 cycles.
- Go while Busy: second Go pulse mid-walk is ignored, giving a single Done and an unchanged trace.
  - Then assert Rst=0 during a walk: all outputs 0 next edge, state IDLE; a fresh Go completes normally.
- COST_SUM_EN: nominal path with M all 8'h03 -> Cost=21. Without the macro, Cost=0 and M_En is never 1.
